// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller signal bundle between the pipeline front end and the sequencer
// master: the sequencer (takes hazard/branch/memory status, drives PC/IF/ID/pipe controls)
// slave : the pipeline side (drives status, takes controls)
`timescale 1ns/1ps
interface pipeline_hazard_ctrl_if #(parameter int RA_W = 5, parameter int CNT_W = 32);
  logic start_i;
  logic idex_memread_i;
  logic [RA_W-1:0] idex_rt_i;
  logic [RA_W-1:0] ifid_rs_i;
  logic [RA_W-1:0] ifid_rt_i;
  logic branch_taken_i;
  logic dmem_req_i;
  logic dmem_ack_i;
  logic pc_write_o;
  logic ifid_write_o;
  logic ifid_flush_o;
  logic idex_bubble_o;
  logic pipe_stall_o;
  logic dmem_strobe_o;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master(
    input start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o, dmem_strobe_o, state_o, stall_cnt_o
  );
  modport slave(
    output start_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    input pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o, dmem_strobe_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: front-end sequencer for PC write, IF/ID write/flush, ID/EX bubble, pipe freeze and dmem handshake
// clk_i, rst_i (async, active-high); bus: pipeline_hazard_ctrl_if.master carrying status in, controls and stall counter out
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int RA_W  = 5
) (
  input logic clk_i,
  input logic rst_i,
  pipeline_hazard_ctrl_if.master bus
);
  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, MEM = 2'b10;
  logic [1:0] state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [RA_W-1:0] rt;
  logic run, mem, lu, adv;
  assign run = state == RUN;
  assign mem = state == MEM;
  assign rt = bus.idex_rt_i;
  assign lu = bus.idex_memread_i & (rt != '0) & (rt == bus.ifid_rs_i | rt == bus.ifid_rt_i);
  // the pipe moves this cycle: normal RUN flow, or the cycle a pending memory access completes
  assign adv = (run & bus.start_i & ~bus.dmem_req_i) | (mem & bus.dmem_ack_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      if ((run | mem) & ~bus.pc_write_o & (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  // 2'b11 falls through to IDLE
  always_comb
    nxt = run ? (!bus.start_i ? IDLE : bus.dmem_req_i ? MEM : RUN)
        : mem ? (bus.dmem_ack_i ? RUN : MEM)
        : (state == IDLE && bus.start_i) ? RUN : IDLE;
  // a load-use hazard wins over a taken branch: the branch is re-resolved after the bubble
  always_comb begin
    bus.pc_write_o = adv & ~lu;
    bus.ifid_write_o = adv & ~lu;
    bus.ifid_flush_o = adv & ~lu & bus.branch_taken_i;
    bus.idex_bubble_o = adv & lu;
    bus.pipe_stall_o = ~adv;
    bus.dmem_strobe_o = mem;
  end
  assign bus.state_o = state;
  assign bus.stall_cnt_o = cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of pipeline_hazard_ctrl against a rule-level model
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int m_state = 0;
  longint total = 0;
  logic e_pcw, e_ifw, e_fl, e_bub, e_stl, e_str;
  pipeline_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) b0();
  pipeline_hazard_ctrl_if #(.RA_W(5), .CNT_W(4)) b1();
  pipeline_hazard_ctrl #(.CNT_W(32), .RA_W(5)) u0(.clk_i(clk_i), .rst_i(rst_i), .bus(b0));
  pipeline_hazard_ctrl #(.CNT_W(4), .RA_W(5)) u1(.clk_i(clk_i), .rst_i(rst_i), .bus(b1));
  assign b1.start_i = b0.start_i;
  assign b1.idex_memread_i = b0.idex_memread_i;
  assign b1.idex_rt_i = b0.idex_rt_i;
  assign b1.ifid_rs_i = b0.ifid_rs_i;
  assign b1.ifid_rt_i = b0.ifid_rt_i;
  assign b1.branch_taken_i = b0.branch_taken_i;
  assign b1.dmem_req_i = b0.dmem_req_i;
  assign b1.dmem_ack_i = b0.dmem_ack_i;
  always #5 clk_i = ~clk_i;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit load_use();
    return b0.idex_memread_i && b0.idex_rt_i != 0 && (b0.idex_rt_i == b0.ifid_rs_i || b0.idex_rt_i == b0.ifid_rt_i);
  endfunction
  task automatic model_out();
    {e_pcw, e_ifw, e_fl, e_bub, e_stl, e_str} = '0;
    if (m_state == 0) e_stl = 1;
    else if (m_state == 2 && !b0.dmem_ack_i) begin
      e_stl = 1;
      e_str = 1;
    end else begin
      if (m_state == 2) e_str = 1;
      if (m_state == 1 && !b0.start_i) e_stl = 1;
      else if (m_state == 1 && b0.dmem_req_i) e_stl = 1;
      else if (load_use()) e_bub = 1;
      else if (b0.branch_taken_i) {e_pcw, e_ifw, e_fl} = 3'b111;
      else {e_pcw, e_ifw} = 2'b11;
    end
  endtask
  task automatic check_all(string tag);
    logic [1:0] es;
    model_out();
    es = 2'(m_state);
    chk({tag, "_outs"}, {b0.pc_write_o, b0.ifid_write_o, b0.ifid_flush_o, b0.idex_bubble_o, b0.pipe_stall_o, b0.dmem_strobe_o, b0.state_o},
        {e_pcw, e_ifw, e_fl, e_bub, e_stl, e_str, es});
    chk({tag, "_outs4"}, {b1.pc_write_o, b1.ifid_write_o, b1.ifid_flush_o, b1.idex_bubble_o, b1.pipe_stall_o, b1.dmem_strobe_o, b1.state_o},
        {e_pcw, e_ifw, e_fl, e_bub, e_stl, e_str, es});
    chk({tag, "_cnt32"}, b0.stall_cnt_o, 32'(total));
    chk({tag, "_cnt4"}, {28'd0, b1.stall_cnt_o}, total > 15 ? 32'd15 : 32'(total));
  endtask
  task automatic model_edge();
    if (m_state != 0 && !e_pcw) total++;
    case (m_state)
      0: m_state = b0.start_i ? 1 : 0;
      1: m_state = !b0.start_i ? 0 : b0.dmem_req_i ? 2 : 1;
      default: m_state = b0.dmem_ack_i ? 1 : 2;
    endcase
  endtask
  task automatic step(string tag, bit s, bit mr, logic [4:0] rt, logic [4:0] rs, logic [4:0] rtd, bit br, bit rq, bit ak);
    b0.start_i = s;
    b0.idex_memread_i = mr;
    b0.idex_rt_i = rt;
    b0.ifid_rs_i = rs;
    b0.ifid_rt_i = rtd;
    b0.branch_taken_i = br;
    b0.dmem_req_i = rq;
    b0.dmem_ack_i = ak;
    #2;
    check_all(tag);
    @(posedge clk_i);
    model_edge();
    #1;
  endtask
  initial begin
    b0.start_i = 0;
    b0.idex_memread_i = 0;
    b0.idex_rt_i = 0;
    b0.ifid_rs_i = 0;
    b0.ifid_rt_i = 0;
    b0.branch_taken_i = 0;
    b0.dmem_req_i = 0;
    b0.dmem_ack_i = 0;
    @(posedge clk_i);
    #1;
    check_all("reset");
    @(posedge clk_i);
    #1;
    rst_i = 0;
    step("t1_c0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1_c1", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1_c2", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_run", b0.state_o, 32'd1);
    step("t1_c3", 1, 0, 0, 0, 0, 0, 0, 0);
    step("t2_lu", 1, 1, 5, 5, 0, 0, 0, 0);
    step("t2_lu_rt", 1, 1, 7, 1, 7, 0, 0, 0);
    step("t2_r0", 1, 1, 0, 0, 0, 0, 0, 0);
    step("t3_br", 1, 0, 5, 5, 5, 1, 0, 0);
    step("t3_brlu", 1, 1, 5, 5, 2, 1, 0, 0);
    step("t4_n", 1, 0, 0, 0, 0, 0, 1, 0);
    step("t4_n1", 0, 0, 0, 0, 0, 0, 0, 0);
    step("t4_n2", 1, 0, 0, 0, 0, 1, 1, 0);
    step("t4_n3", 0, 1, 3, 3, 3, 0, 0, 0);
    step("t4_n4", 0, 0, 0, 0, 0, 1, 1, 1);
    chk("t4_run", b0.state_o, 32'd1);
    step("t4_n5", 1, 0, 0, 0, 0, 0, 0, 1);
    step("t5_req", 1, 0, 0, 0, 0, 0, 1, 0);
    step("t5_mem", 1, 0, 0, 0, 0, 0, 1, 0);
    rst_i = 1;
    #1;
    chk("t5_strobe", b0.dmem_strobe_o, 32'd0);
    chk("t5_state", b0.state_o, 32'd0);
    chk("t5_cnt32", b0.stall_cnt_o, 32'd0);
    chk("t5_cnt4", {28'd0, b1.stall_cnt_o}, 32'd0);
    #1;
    rst_i = 0;
    m_state = 0;
    total = 0;
    #1;
    check_all("t5_post");
    @(posedge clk_i);
    model_edge();
    #1;
    step("t6_go", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("t6_lu", 1, 1, 9, 1, 9, 0, 0, 0);
    chk("t6_sat", {28'd0, b1.stall_cnt_o}, 32'd15);
    step("t6_hold", 1, 1, 9, 9, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(9, 0) != 0, 1'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
           5'($urandom_range(3, 0)), $urandom_range(2, 0) == 0, $urandom_range(6, 0) == 0, $urandom_range(2, 0) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
